// File: rtl/mul_pkg.sv
// Shared constants and types for the multiply datapath normalize/round stage.
// Holds field widths, the finite-exponent and mantissa saturation values, the
// stage-1 pipeline record, and a helper that widens the incoming exponent.
package mul_pkg;

  localparam int EXP_W  = 8;    // output biased exponent width
  localparam int MAN_W  = 12;   // output mantissa width, hidden bit at MAN_W-1
  localparam int PROD_W = 16;   // input product width
  localparam int EIN_W  = 10;   // incoming signed exponent width
  localparam int EINT_W = 11;   // internal signed exponent width (room for +1 +1)

  localparam int              EXP_BIAS       = 127;
  localparam logic [EXP_W-1:0] EXP_MAX_FINITE = 8'd254;
  localparam logic [MAN_W-1:0] MAN_MAX        = 12'hFFF;

  // First exponent value that no longer fits a finite result (all-ones field).
  localparam logic [EINT_W-1:0] EXP_OVF = EINT_W'(2 * EXP_BIAS + 1);

  // Stage-1 pipeline record: normalized exponent plus the rounding fields.
  typedef struct packed {
    logic              valid;
    logic              sign;
    logic              zero;
    logic [EINT_W-1:0] e;
    logic [MAN_W-1:0]  keep;
    logic              guard;
    logic              sticky;
  } stage1_t;

  // Sign-extend the incoming exponent to the internal width.
  function automatic logic [EINT_W-1:0] sext_exp(input logic [EIN_W-1:0] x);
    return {x[EIN_W-1], x};
  endfunction

endpackage

// File: rtl/mul_norm_round_if.sv
// Datapath bus between the mantissa multiplier and the normalize/round stage.
//   in_valid/in_sign/in_exp/in_man : multiplier result fields (master drives)
//   out_valid/out_sign/out_exp/out_man/out_inexact : rounded result (slave drives)
interface mul_norm_round_if;
  import mul_pkg::*;

  logic              in_valid;
  logic              in_sign;
  logic [EIN_W-1:0]  in_exp;
  logic [PROD_W-1:0] in_man;

  logic              out_valid;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MAN_W-1:0]  out_man;
  logic              out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_man,
    input  out_valid, out_sign, out_exp, out_man, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_man,
    output out_valid, out_sign, out_exp, out_man, out_inexact
  );
endinterface

// File: rtl/mul_round_rne.sv
// Combinational round-to-nearest-even on an already normalized mantissa.
//   keep    : 12-bit mantissa to keep (hidden bit at MSB)
//   guard   : first bit below keep
//   sticky  : OR of the remaining visible bits
//   man     : rounded mantissa (0x800 when rounding overflows the field)
//   carry   : rounding overflowed; caller bumps the exponent
//   inexact : any discarded bit was set
module mul_round_rne
  import mul_pkg::*;
(
  input  logic [MAN_W-1:0] keep,
  input  logic             guard,
  input  logic             sticky,
  output logic [MAN_W-1:0] man,
  output logic             carry,
  output logic             inexact
);

  logic             round_up;
  logic [MAN_W:0]   sum;

  // Increment on above-half, or on exact half when keep is odd (ties to even).
  always_comb begin
    round_up = guard & (sticky | keep[0]);
    sum      = {1'b0, keep} + {{MAN_W{1'b0}}, round_up};
    carry    = sum[MAN_W];
    inexact  = guard | sticky;
    if (sum[MAN_W]) begin
      man = {1'b1, {(MAN_W-1){1'b0}}};
    end else begin
      man = sum[MAN_W-1:0];
    end
  end

endmodule

// File: rtl/mul_norm_round.sv
// Normalize-and-round stage after the mantissa multiplier.
// Two-stage pipeline: stage 1 normalizes and splits the round fields,
// stage 2 rounds, resolves exponent overflow/underflow and registers outputs.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : input product fields and registered result fields
//   flag_clr      : clear sticky flags (a result flagging on the same edge wins)
//   flag_ovf/unf/nx : sticky overflow / underflow / inexact
module mul_norm_round
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  mul_norm_round_if.slave   bus,
  input  logic              flag_clr,
  output logic              flag_ovf,
  output logic              flag_unf,
  output logic              flag_nx
);

  logic [PROD_W-1:0] n;
  logic [EINT_W-1:0] e_norm;
  logic              zero_in;
  stage1_t           s1;

  logic [MAN_W-1:0]  rnd_man;
  logic              rnd_carry;
  logic              rnd_nx;
  logic [EINT_W-1:0] e_rnd;

  logic [EXP_W-1:0]  res_exp;
  logic [MAN_W-1:0]  res_man;
  logic              res_nx;
  logic              res_ovf;
  logic              res_unf;

  // Normalize: leading one at bit 15 bumps the exponent, at bit 14 shifts up.
  always_comb begin
    zero_in = (bus.in_man[PROD_W-1:PROD_W-2] == 2'b00);
    if (bus.in_man[PROD_W-1]) begin
      n      = bus.in_man;
      e_norm = sext_exp(bus.in_exp) + 11'd1;
    end else begin
      n      = {bus.in_man[PROD_W-2:0], 1'b0};
      e_norm = sext_exp(bus.in_exp);
    end
  end

  // Stage 1 register: fields captured only on valid inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1.sign   <= bus.in_sign;
        s1.zero   <= zero_in;
        s1.e      <= e_norm;
        s1.keep   <= n[PROD_W-1:4];
        s1.guard  <= n[3];
        s1.sticky <= |n[2:0];
      end
    end
  end

  mul_round_rne u_rne (
    .keep    (s1.keep),
    .guard   (s1.guard),
    .sticky  (s1.sticky),
    .man     (rnd_man),
    .carry   (rnd_carry),
    .inexact (rnd_nx)
  );

  // Exponent resolve after rounding; e_rnd is treated as signed.
  always_comb begin
    e_rnd   = s1.e + {{(EINT_W-1){1'b0}}, rnd_carry};
    res_exp = 8'd0;
    res_man = 12'd0;
    res_nx  = 1'b0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (s1.zero) begin
      res_exp = 8'd0;
    end else if ($signed(e_rnd) >= $signed(EXP_OVF)) begin
      res_exp = EXP_MAX_FINITE;
      res_man = MAN_MAX;
      res_nx  = 1'b1;
      res_ovf = 1'b1;
    end else if ($signed(e_rnd) <= $signed(11'd0)) begin
      res_nx  = 1'b1;
      res_unf = 1'b1;
    end else begin
      res_exp = e_rnd[EXP_W-1:0];
      res_man = rnd_man;
      res_nx  = rnd_nx;
    end
  end

  // Stage 2 register: outputs hold until the next valid result; flags are sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out_sign    <= 1'b0;
      bus.out_exp     <= 8'd0;
      bus.out_man     <= 12'd0;
      bus.out_inexact <= 1'b0;
      flag_ovf        <= 1'b0;
      flag_unf        <= 1'b0;
      flag_nx         <= 1'b0;
    end else begin
      bus.out_valid <= s1.valid;
      if (s1.valid) begin
        bus.out_sign    <= s1.sign;
        bus.out_exp     <= res_exp;
        bus.out_man     <= res_man;
        bus.out_inexact <= res_nx;
      end
      // Clear first, then OR in this edge's result so a coinciding flag survives.
      flag_ovf <= (flag_ovf & ~flag_clr) | (s1.valid & res_ovf);
      flag_unf <= (flag_unf & ~flag_clr) | (s1.valid & res_unf);
      flag_nx  <= (flag_nx  & ~flag_clr) | (s1.valid & res_nx);
    end
  end

endmodule

// File: tb/tb_mul_norm_round.sv
// Directed bench for mul_norm_round: hand-computed vectors, immediate assertions.
module tb_mul_norm_round;

  logic clk = 1'b0;
  logic rst;
  logic flag_clr;
  logic flag_ovf, flag_unf, flag_nx;
  int   n_assert = 0;
  int   n_fail   = 0;

  mul_norm_round_if bus ();

  mul_norm_round dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flag_clr (flag_clr),
    .flag_ovf (flag_ovf),
    .flag_unf (flag_unf),
    .flag_nx  (flag_nx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic v, input logic s, input logic [9:0] e, input logic [15:0] m);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_man   = m;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic s, input logic [7:0] e,
                           input logic [11:0] m, input logic nx);
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_sign"}, 16'(bus.out_sign), 16'(s));
    chk({tag, "_exp"}, 16'(bus.out_exp), 16'(e));
    chk({tag, "_man"}, 16'(bus.out_man), 16'(m));
    chk({tag, "_inexact"}, 16'(bus.out_inexact), 16'(nx));
  endtask

  // One isolated input; result is visible after the second rising edge.
  task automatic run_one(input string tag, input logic s, input logic [9:0] e, input logic [15:0] m,
                         input logic [7:0] xe, input logic [11:0] xm, input logic xnx);
    step(1'b1, s, e, m);
    step(1'b0, 1'b0, 10'd0, 16'd0);
    check_out(tag, s, xe, xm, xnx);
  endtask

  initial begin
    rst = 1'b1;
    flag_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exp = 10'd0;
    bus.in_man = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_exp", 16'(bus.out_exp), 16'd0);
    chk("rst_man", 16'(bus.out_man), 16'd0);
    chk("rst_flags", 16'({flag_ovf, flag_unf, flag_nx}), 16'd0);
    rst = 1'b0;

    run_one("norm15", 1'b0, 10'd10, 16'h8000, 8'd11, 12'h800, 1'b0);
    run_one("norm14", 1'b0, 10'd10, 16'h4000, 8'd10, 12'h800, 1'b0);
    chk("flags_clean", 16'({flag_ovf, flag_unf, flag_nx}), 16'd0);
    run_one("rnd_up", 1'b0, 10'd100, 16'h8018, 8'd101, 12'h802, 1'b1);
    chk("nx_set", 16'(flag_nx), 16'd1);
    run_one("tie_even", 1'b1, 10'd100, 16'h8008, 8'd101, 12'h800, 1'b1);
    run_one("rnd_carry", 1'b0, 10'd100, 16'hFFF8, 8'd102, 12'h800, 1'b1);
    run_one("zero", 1'b1, 10'd50, 16'h0000, 8'd0, 12'h000, 1'b0);
    chk("zero_noflag", 16'({flag_ovf, flag_unf}), 16'd0);
    run_one("max_fin", 1'b0, 10'd253, 16'h8000, 8'd254, 12'h800, 1'b0);
    run_one("min_norm", 1'b0, 10'd1, 16'h4000, 8'd1, 12'h800, 1'b0);
    chk("bound_noflag", 16'({flag_ovf, flag_unf}), 16'd0);

    flag_clr = 1'b1;
    step(1'b0, 1'b0, 10'd0, 16'd0);
    flag_clr = 1'b0;
    chk("clr_idle", 16'({flag_ovf, flag_unf, flag_nx}), 16'd0);

    // Overflow with flag_clr on the emerging edge: set wins, then clear.
    step(1'b1, 1'b1, 10'd254, 16'h8000);
    flag_clr = 1'b1;
    step(1'b0, 1'b0, 10'd0, 16'd0);
    check_out("ovf", 1'b1, 8'd254, 12'hFFF, 1'b1);
    chk("ovf_setwins", 16'({flag_ovf, flag_unf, flag_nx}), 16'b101);
    step(1'b0, 1'b0, 10'd0, 16'd0);
    flag_clr = 1'b0;
    chk("ovf_cleared", 16'({flag_ovf, flag_unf, flag_nx}), 16'd0);

    run_one("unf", 1'b0, 10'd0, 16'h4000, 8'd0, 12'h000, 1'b1);
    chk("unf_flags", 16'({flag_ovf, flag_unf, flag_nx}), 16'b011);
    run_one("unf_neg", 1'b1, 10'h3FB, 16'h8000, 8'd0, 12'h000, 1'b1);

    // Back-to-back A, B, bubble, C.
    step(1'b1, 1'b0, 10'd10, 16'h8000);
    chk("b2b_pre", 16'(bus.out_valid), 16'd0);
    step(1'b1, 1'b0, 10'd20, 16'h4000);
    check_out("b2b_a", 1'b0, 8'd11, 12'h800, 1'b0);
    step(1'b0, 1'b0, 10'd0, 16'd0);
    check_out("b2b_b", 1'b0, 8'd20, 12'h800, 1'b0);
    step(1'b1, 1'b0, 10'd30, 16'h8018);
    chk("b2b_bubble_v", 16'(bus.out_valid), 16'd0);
    chk("b2b_bubble_hold", 16'(bus.out_exp), 16'd20);
    step(1'b0, 1'b0, 10'd0, 16'd0);
    check_out("b2b_c", 1'b0, 8'd31, 12'h802, 1'b1);
    step(1'b0, 1'b0, 10'd0, 16'd0);
    chk("b2b_end", 16'(bus.out_valid), 16'd0);

    // Reset mid-stream drops the in-flight result.
    step(1'b1, 1'b0, 10'd40, 16'h8000);
    step(1'b1, 1'b0, 10'd50, 16'h8000);
    chk("mid_pre", 16'(bus.out_valid), 16'd1);
    rst = 1'b1;
    step(1'b0, 1'b0, 10'd0, 16'd0);
    rst = 1'b0;
    chk("mid_rst_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_exp", 16'(bus.out_exp), 16'd0);
    chk("mid_rst_flags", 16'({flag_ovf, flag_unf, flag_nx}), 16'd0);
    step(1'b0, 1'b0, 10'd0, 16'd0);
    chk("mid_dropped", 16'(bus.out_valid), 16'd0);
    run_one("post_rst", 1'b0, 10'd60, 16'h8000, 8'd61, 12'h800, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
